// File: rtl/helios_pkg.sv
// Shared Helios host-protocol constants, FSM state type and small helpers.
package helios_pkg;

  localparam logic [7:0] START_DECODING_MSG      = 8'h01;
  localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02;
  localparam int         RESULT_BYTES            = 3;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_HDR,
    LOAD,
    RUN,
    RESULT
  } host_if_state_t;

  // Cycle counter holds at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/helios_host_interface_if.sv
// Inbound and outbound 8-bit valid/ready byte streams between host FIFOs and the decoder endpoint.
interface helios_host_interface_if;
  logic [7:0] input_data;
  logic       input_valid;
  logic       input_ready;
  logic [7:0] output_data;
  logic       output_valid;
  logic       output_ready;

  modport slave (
    input  input_data, input_valid,
    output input_ready,
    output output_data, output_valid,
    input  output_ready
  );

  modport master (
    output input_data, input_valid,
    input  input_ready,
    input  output_data, output_valid,
    output output_ready
  );
endinterface

// File: rtl/helios_result_serializer.sv
// Latches {iteration, cycles} and streams them as three bytes under valid/ready.
module helios_result_serializer
  import helios_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [7:0]  iteration,
  input  logic [15:0] cycles,
  output logic [7:0]  data,
  output logic        valid,
  input  logic        ready,
  output logic        last_sent
);

  localparam int IW = $clog2(RESULT_BYTES);

  logic [IW-1:0] idx;
  logic [15:0]   cyc_q;
  logic          is_last;

  assign is_last   = (idx == IW'(RESULT_BYTES - 1));
  assign last_sent = valid & ready & is_last;

  // Data only changes on a transfer or a new load, so it is stable while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= 8'h00;
      idx   <= '0;
      cyc_q <= 16'h0000;
    end else if (load) begin
      valid <= 1'b1;
      data  <= iteration;
      cyc_q <= cycles;
      idx   <= '0;
    end else if (valid && ready) begin
      if (is_last) begin
        valid <= 1'b0;
      end else begin
        idx  <= idx + IW'(1);
        data <= (idx == '0) ? cyc_q[15:8] : cyc_q[7:0];
      end
    end
  end

endmodule

// File: rtl/helios_host_interface.sv
// Helios host endpoint: parses START/header/measurement bytes, starts and times the decode, returns a 3-byte result.
module helios_host_interface
  import helios_pkg::*;
#(
  parameter  int GRID_WIDTH_X         = 3,
  parameter  int GRID_WIDTH_Z         = 2,
  parameter  int GRID_WIDTH_U         = 3,
  localparam int BYTES_PER_ROUND      = (GRID_WIDTH_X * GRID_WIDTH_Z + 7) >> 3,
  localparam int ALIGNED_PU_PER_ROUND = BYTES_PER_ROUND * 8,
  localparam int MEAS_BYTES           = BYTES_PER_ROUND * GRID_WIDTH_U
) (
  input  logic                                         clk,
  input  logic                                         reset,
  helios_host_interface_if.slave                       host,
  output logic [ALIGNED_PU_PER_ROUND*GRID_WIDTH_U-1:0] measurements,
  output logic                                         decode_start,
  input  logic                                         decode_done,
  input  logic [7:0]                                   iteration_count
);

  localparam int IDX_W = (MEAS_BYTES > 1) ? $clog2(MEAS_BYTES) : 1;

  host_if_state_t                  state;
  logic                            in_rdy;
  logic [IDX_W-1:0]                idx;
  logic [15:0]                     cnt;
  logic [MEAS_BYTES-1:0][7:0]      meas_q;
  logic                            acc;
  logic                            res_load;
  logic                            last_sent;

  assign acc              = host.input_valid & in_rdy;
  assign host.input_ready = in_rdy;
  assign measurements     = meas_q;

  // decode_start doubles as the first-RUN-cycle marker, where done is ignored.
  assign res_load = (state == RUN) && !decode_start && decode_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      in_rdy       <= 1'b0;
      decode_start <= 1'b0;
      idx          <= '0;
      cnt          <= 16'h0000;
      meas_q       <= '0;
    end else begin
      decode_start <= 1'b0;
      case (state)
        IDLE: begin
          in_rdy <= 1'b1;
          if (acc && host.input_data == START_DECODING_MSG) state <= WAIT_HDR;
        end
        WAIT_HDR: begin
          if (acc && host.input_data == MEASUREMENT_DATA_HEADER) begin
            state <= LOAD;
            idx   <= '0;
          end
        end
        LOAD: begin
          if (acc) begin
            meas_q[idx] <= host.input_data;
            idx         <= idx + IDX_W'(1);
            if (idx == IDX_W'(MEAS_BYTES - 1)) begin
              state        <= RUN;
              in_rdy       <= 1'b0;
              decode_start <= 1'b1;
              cnt          <= 16'h0000;
            end
          end
        end
        RUN: begin
          if (!decode_start) begin
            if (decode_done) state <= RESULT;
            else             cnt   <= sat_inc16(cnt);
          end
        end
        RESULT: begin
          if (last_sent) begin
            state  <= WAIT_HDR;
            in_rdy <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  helios_result_serializer u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (res_load),
    .iteration (iteration_count),
    .cycles    (cnt),
    .data      (host.output_data),
    .valid     (host.output_valid),
    .ready     (host.output_ready),
    .last_sent (last_sent)
  );

endmodule

// File: tb/tb_helios_host_interface.sv
// Self-checking bench for helios_host_interface against a byte-level protocol model.
module tb_helios_host_interface;

  localparam int X  = 3;
  localparam int Z  = 2;
  localparam int U  = 3;
  localparam int MW = (((X * Z + 7) >> 3) * 8) * U;

  logic          clk = 1'b0;
  logic          reset;
  logic [MW-1:0] measurements;
  logic          decode_start;
  logic          decode_done;
  logic [7:0]    iteration_count;

  int vectors = 0;
  int errors  = 0;
  int start_pulses = 0;

  helios_host_interface_if hif();

  helios_host_interface #(
    .GRID_WIDTH_X(X), .GRID_WIDTH_Z(Z), .GRID_WIDTH_U(U)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .host            (hif),
    .measurements    (measurements),
    .decode_start    (decode_start),
    .decode_done     (decode_done),
    .iteration_count (iteration_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (decode_start === 1'b1) start_pulses++;

  // Reference: byte i of the stream lands in bits [8i+7:8i].
  function automatic logic [MW-1:0] model_meas(input logic [7:0] b0, b1, b2);
    logic [MW-1:0] v;
    v = '0;
    v[7:0] = b0; v[15:8] = b1; v[23:16] = b2;
    return v;
  endfunction

  // Reference: done seen n cycles after the start cycle reports n-1, clamped to 16 bits.
  function automatic logic [15:0] model_cycles(input int n);
    return (n - 1 > 65535) ? 16'hFFFF : 16'(n - 1);
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    hif.input_data  = b;
    hif.input_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (hif.input_ready === 1'b1) begin @(posedge clk); #1; ok = 1'b1; end
    end
    hif.input_valid = 1'b0;
    vectors++;
    if (!ok) begin errors++; $display("FAIL send_timeout byte=%h not accepted within 50 cycles", b); end
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    tick(n);
    reset = 1'b0;
  endtask

  // Called in the cycle right after the last measurement byte transfer.
  task automatic run_decode(input int n, input logic [7:0] iter);
    @(negedge clk);
    vectors++;
    if (decode_start !== 1'b1 || hif.input_ready !== 1'b0) begin
      errors++;
      $display("FAIL start_cycle decode_start=%b input_ready=%b required 1/0", decode_start, hif.input_ready);
    end
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      if (k == n) begin decode_done = 1'b1; iteration_count = iter; end
      if (k == 1) begin
        @(negedge clk);
        vectors++;
        if (decode_start !== 1'b0) begin
          errors++; $display("FAIL start_one_cycle decode_start=%b required 0", decode_start);
        end
      end
    end
    @(posedge clk); #1;
    decode_done     = 1'b0;
    iteration_count = 8'($urandom);
  endtask

  // Called in the cycle after done was sampled; expects three bytes e0,e1,e2 once each.
  task automatic recv_result(input bit stall, input logic [7:0] e0, e1, e2);
    logic [7:0] expb [3];
    logic [7:0] held;
    bit         hadheld;
    int         got, cyc;
    expb = '{e0, e1, e2};
    got = 0; cyc = 0; hadheld = 1'b0; held = 8'h00;
    hif.output_ready = stall ? 1'b0 : 1'b1;
    @(negedge clk);
    vectors++;
    if (hif.output_valid !== 1'b1) begin
      errors++; $display("FAIL first_byte_latency output_valid=%b required 1", hif.output_valid);
    end
    while (got < 3 && cyc < 300) begin
      if (hif.output_valid === 1'b1) begin
        if (hadheld) begin
          vectors++;
          if (hif.output_data !== held) begin
            errors++; $display("FAIL stall_stable data=%h required %h", hif.output_data, held);
          end
        end
        if (hif.output_ready) begin
          vectors++;
          if (hif.output_data !== expb[got]) begin
            errors++; $display("FAIL result_byte%0d got=%h required %h", got, hif.output_data, expb[got]);
          end
          got++; hadheld = 1'b0;
        end else begin
          held = hif.output_data; hadheld = 1'b1;
        end
      end
      if (hif.input_ready !== 1'b0) begin
        vectors++; errors++; $display("FAIL result_backpressure input_ready=%b required 0", hif.input_ready);
      end
      @(posedge clk); #1;
      cyc++;
      if (stall) hif.output_ready = (cyc < 10) ? 1'b0 : ~hif.output_ready;
      @(negedge clk);
    end
    vectors++;
    if (got < 3) begin errors++; $display("FAIL result_timeout got %0d bytes required 3", got); end
    hif.output_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (hif.output_valid !== 1'b0) begin
        errors++; $display("FAIL extra_byte output_valid=%b required 0", hif.output_valid);
      end
      @(negedge clk);
    end
    vectors++;
    if (hif.input_ready !== 1'b1) begin
      errors++; $display("FAIL back_to_hdr input_ready=%b required 1", hif.input_ready);
    end
    @(posedge clk); #1;
  endtask

  // One full round: optional START, header, random bytes, random decode time.
  task automatic do_round(input bit with_start, input bit stall, input int n);
    logic [7:0] b0, b1, b2, iter;
    logic [15:0] c;
    b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); iter = 8'($urandom);
    if (with_start) send_byte(8'h01);
    send_byte(8'h02);
    send_byte(b0); send_byte(b1); send_byte(b2);
    vectors++;
    if (measurements !== model_meas(b0, b1, b2)) begin
      errors++; $display("FAIL round_meas got=%h required %h", measurements, model_meas(b0, b1, b2));
    end
    run_decode(n, iter);
    c = model_cycles(n);
    recv_result(stall, iter, c[15:8], c[7:0]);
    vectors++;
    if (measurements !== model_meas(b0, b1, b2)) begin
      errors++; $display("FAIL meas_stable got=%h required %h", measurements, model_meas(b0, b1, b2));
    end
  endtask

  task automatic test_reset();
    apply_reset(3);
    vectors++;
    if (hif.output_valid !== 1'b0 || hif.output_data !== 8'h00 || decode_start !== 1'b0 ||
        measurements !== '0) begin
      errors++;
      $display("FAIL reset_outputs valid=%b data=%h start=%b meas=%h required 0/00/0/0",
               hif.output_valid, hif.output_data, decode_start, measurements);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (hif.input_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready input_ready=%b required 0", hif.input_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    tick(2);
    vectors++;
    if (hif.input_ready !== 1'b1) begin
      errors++; $display("FAIL idle_ready input_ready=%b required 1", hif.input_ready);
    end
  endtask

  task automatic test_basic();
    int p0;
    p0 = start_pulses;
    send_byte(8'h01); send_byte(8'h02);
    send_byte(8'hA5); send_byte(8'h3C); send_byte(8'h7E);
    vectors++;
    if (measurements !== 24'h7E3CA5) begin
      errors++; $display("FAIL basic_meas got=%h required 7e3ca5", measurements);
    end
    run_decode(5, 8'h07);
    recv_result(1'b0, 8'h07, 8'h00, 8'h04);
    vectors++;
    if (start_pulses - p0 != 1) begin
      errors++; $display("FAIL basic_pulses got=%0d required 1", start_pulses - p0);
    end
  endtask

  task automatic test_stall();
    send_byte(8'h02);
    send_byte(8'hA5); send_byte(8'h3C); send_byte(8'h7E);
    run_decode(5, 8'h07);
    recv_result(1'b1, 8'h07, 8'h00, 8'h04);
  endtask

  task automatic test_junk();
    int p0;
    apply_reset(2);
    tick(2);
    decode_done = 1'b1; iteration_count = 8'h55;
    tick(3);
    decode_done = 1'b0;
    p0 = start_pulses;
    send_byte(8'hFF); send_byte(8'h02);
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
    tick(3);
    vectors++;
    if (start_pulses != p0 || measurements !== '0 || hif.output_valid !== 1'b0) begin
      errors++;
      $display("FAIL junk_idle pulses=%0d meas=%h valid=%b required 0/0/0",
               start_pulses - p0, measurements, hif.output_valid);
    end
    send_byte(8'h01);
    send_byte(8'h01);
    do_round(1'b0, 1'b0, int'($urandom_range(2, 30)));
  endtask

  task automatic test_saturate();
    do_round(1'b0, 1'b0, 70000);
  endtask

  task automatic test_reset_midload();
    int p0;
    send_byte(8'h02);
    send_byte(8'hC7);
    apply_reset(2);
    vectors++;
    if (measurements !== '0) begin
      errors++; $display("FAIL midload_reset meas=%h required 0", measurements);
    end
    tick(2);
    p0 = start_pulses;
    send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    tick(3);
    vectors++;
    if (start_pulses != p0 || measurements !== '0) begin
      errors++;
      $display("FAIL start_required pulses=%0d meas=%h required 0/0", start_pulses - p0, measurements);
    end
    do_round(1'b1, 1'b0, int'($urandom_range(1, 20)));
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 4; r++)
      do_round(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(1, 300)));
  endtask

  initial begin
    reset            = 1'b1;
    hif.input_data   = 8'h00;
    hif.input_valid  = 1'b0;
    hif.output_ready = 1'b0;
    decode_done      = 1'b0;
    iteration_count  = 8'h00;
    test_reset();
    test_basic();
    test_stall();
    test_junk();
    test_saturate();
    test_reset_midload();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/helios_host_interface.md
# helios_host_interface

Decoder-side endpoint of the Helios 8-bit host byte protocol. It parses the inbound valid/ready byte stream (start command, measurement header, packed measurement bytes), assembles the measurement vector, and pulses the decoder core to start. It times the decode and returns a 3-byte result message on the outbound valid/ready stream. It sits between the host FIFOs and the Helios decoding core inside `Helios_single_FPGA`.

## Interface
Parameters:
- `GRID_WIDTH_X`, default 3: PU grid X extent.
- `GRID_WIDTH_Z`, default 2: PU grid Z extent.
- `GRID_WIDTH_U`, default 3: measurement rounds.
- Derived `BYTES_PER_ROUND` = (X·Z+7)>>3.
- Derived `ALIGNED_PU_PER_ROUND` = BYTES_PER_ROUND·8.
- Derived `MEAS_BYTES` = BYTES_PER_ROUND·GRID_WIDTH_U.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `input_data`  in  8  inbound byte.
- `input_valid`  in  1  inbound byte present.
- `input_ready`  out  1  block accepts inbound byte.
- `output_data`  out  8  outbound result byte.
- `output_valid`  out  1  outbound byte present.
- `output_ready`  in  1  sink accepts outbound byte.
- `measurements`  out  ALIGNED_PU_PER_ROUND·GRID_WIDTH_U  packed syndrome bits to core.
- `decode_start`  out  1  one-cycle start pulse to core.
- `decode_done`  in  1  core finished (level or pulse).
- `iteration_count`  in  8  core iteration count, valid while `decode_done` is high.

## Operation
- Inbound byte transfer on posedge with `input_valid & input_ready`. Outbound byte transfer on posedge with `output_valid & output_ready`.
- FSM states and transitions:
  - IDLE: `input_ready`=1. Byte == START_DECODING_MSG → WAIT_HDR. Any other byte is consumed and dropped.
  - WAIT_HDR: `input_ready`=1. Byte == MEASUREMENT_DATA_HEADER → LOAD, byte index cleared to 0. Any other byte, including a repeated START, is consumed and dropped.
  - LOAD: `input_ready`=1. Accepted byte b is written to `measurements[idx*8 +: 8]` and idx increments. The byte with idx == MEAS_BYTES-1 → RUN.
  - RUN: `input_ready`=0. `decode_start`=1 in the first RUN cycle only, and the cycle counter clears to 0 in that cycle. The counter increments by 1 in each later RUN cycle in which `decode_done` is low. When `decode_done` is sampled high (not in the first cycle), latch `iteration_count` and the counter value → RESULT.
  - RESULT: `output_valid`=1. Byte 0 = iteration count, byte 1 = cycles[15:8], byte 2 = cycles[7:0]. The byte index advances on each transfer. After byte 2 transfers → WAIT_HDR.
- START is required once after reset only. Later rounds begin directly with a header.
- Cycle counter: 16 bits, saturates at 16'hFFFF with no wrap.
- `decode_done` is ignored in every state other than RUN.
- `measurements` is not cleared between rounds. Each LOAD overwrites all MEAS_BYTES bytes. The value is stable from the first RUN cycle until the next LOAD write.

## Timing
- Reset values: `input_ready`=0 in the reset cycle, then 1 in IDLE; `output_valid`=0; `output_data`=0; `decode_start`=0; `measurements`=0; counter=0; state=IDLE.
- Reset asserted mid-LOAD, RUN or RESULT aborts the round and returns to IDLE. Any pending result is discarded and START is required again.
- Latency: `decode_start` is high in the cycle immediately after the last measurement byte transfer.
- Reported cycle count = number of cycles from the `decode_start` cycle to the cycle before `decode_done` is sampled. Example: done sampled 5 cycles after the start cycle → count 4.
- The first result byte is presented in the cycle after `decode_done` is sampled.
- `output_valid` and `output_data` stay stable while `output_ready`=0. There is no combinational path from `output_ready` to `output_valid`.
- `input_ready` is a registered state decode with no combinational dependence on `input_valid`.
- Inbound bytes arriving during RUN or RESULT are back-pressured, not dropped.

## Structure
- Shared package `helios_pkg`:
  - START_DECODING_MSG = 8'h01.
  - MEASUREMENT_DATA_HEADER = 8'h02.
  - `host_if_state_t` enum (IDLE, WAIT_HDR, LOAD, RUN, RESULT).
  - Result message length constant RESULT_BYTES = 3.
- Sub-module `helios_result_serializer`: latches {iteration, cycles} and streams the 3 bytes under valid/ready; it signals last-byte-sent back to the FSM.

## Test plan
- Defaults, stream 01,02,A5,3C,7E → `measurements` = 24'h7E3CA5; `decode_start` high exactly one cycle, the cycle after the 7E transfer.
- `decode_done` sampled 5 cycles after start, `iteration_count`=8'h07 → output bytes 07,00,04.
- Outbound sink holds `output_ready`=0 for 10 cycles, then toggles 1/0 → bytes 07,00,04 each sent exactly once, with data stable while stalled.
- Junk bytes FF,02 in IDLE → no state change past IDLE (02 dropped). A later 01 enables header parsing. A second 01 in WAIT_HDR is dropped.
- `decode_done` held low for 70000 cycles → cycle bytes FF,FF (saturated).
- Reset asserted mid-LOAD after 1 byte, then a full new stream → `measurements` reflects only the new bytes and START is required again. Back-to-back rounds (header only, no START) produce two correct result messages.
